// File: rtl/data_playback.sv
// -----------------------------------------------------------------------------
// data_playback
//   Simulation stream source. Plays a byte image out as DATA_WIDTH-bit words
//   on a valid/ready bus. Image byte 0 lands in data[7:0].
//   A one-cycle done pulse follows acceptance of the last word.
//
//   Byte source:
//     Bytes come from the INIT_BYTES image (INIT_LEN bytes, at most 128;
//     byte i is INIT_BYTES[8*i +: 8]). FILENAME is retained as a label.
//
//   Optional feature macro: DATA_PLAYBACK_LOOP_EN
//     When defined, playback rewinds at EOF and continues for NUM_LOOPS passes
//     without a bubble. When undefined, playback is single pass.
//
//   Ports:
//     clk       in   1           clock
//     rst_n     in   1           async reset, active low
//     start     in   1           begin playback (sampled only in IDLE)
//     data      out  DATA_WIDTH  presented word
//     valid     out  1           data is presented
//     ready     in   1           downstream accepts (transfer = valid & ready)
//     done      out  1           one-cycle pulse after the last word is accepted
//     busy      out  1           high from start until done
//     word_cnt  out  32          accepted words since reset (wraps)
// -----------------------------------------------------------------------------
module data_playback #(
    parameter string         FILENAME   = "input_data.bin",
    parameter int            DATA_WIDTH = 8,
    parameter int            MODE       = 0,
    parameter int            BURST_LEN  = 4,
    parameter int            GAP_LEN    = 3,
    parameter int            NUM_LOOPS  = 2,
    parameter int            INIT_LEN   = 0,
    parameter logic [1023:0] INIT_BYTES = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  done,
    output logic                  busy,
    output logic [31:0]           word_cnt
);

    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // One raw read: how many bytes were found and the zero-padded word.
    typedef struct packed {
        logic [7:0]            nbytes;
        logic [DATA_WIDTH-1:0] word;
    } rd_t;

    // Result of fetching the next word, including any rewind between passes.
    typedef struct packed {
        logic                  eof;
        logic [DATA_WIDTH-1:0] word;
        logic [31:0]           next_pos;
        logic [31:0]           next_pass;
    } fetch_t;

    // Read up to NB bytes starting at byte offset pos; missing bytes read as zero.
    function automatic rd_t read_word(input logic [31:0] pos);
        rd_t  r;
        int   n;
        int   p;
        r = '0;
        n = 0;
        for (int i = 0; i < NB; i++) begin
            p = int'(pos) + i;
            if ((p < INIT_LEN) && (p < 128)) begin
                r.word[8*i +: 8] = INIT_BYTES[8*p +: 8];
                n = n + 1;
            end else begin
                r.word[8*i +: 8] = 8'h00;
            end
        end
        r.nbytes = 8'(n);
        return r;
    endfunction

    // Fetch the word at pos; with looping enabled, an EOF before the final
    // pass is replaced by the first word of the next pass.
    function automatic fetch_t fetch_next(input logic [31:0] pos, input logic [31:0] pass);
        fetch_t f;
        rd_t    rd;
        rd          = read_word(pos);
        f.eof       = 1'b0;
        f.word      = rd.word;
        f.next_pos  = pos + 32'(rd.nbytes);
        f.next_pass = pass;
        if (rd.nbytes == 8'd0) begin
`ifdef DATA_PLAYBACK_LOOP_EN
            if ((pass + 32'd1) < 32'(NUM_LOOPS)) begin
                rd          = read_word(32'd0);
                f.word      = rd.word;
                f.next_pos  = 32'(rd.nbytes);
                f.next_pass = pass + 32'd1;
                f.eof       = (rd.nbytes == 8'd0);
            end else begin
                f.eof = 1'b1;
            end
`else
            f.eof = 1'b1;
`endif
        end else begin
            f.eof = 1'b0;
        end
        return f;
    endfunction

    state_t                state_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r;
    logic                  done_r;
    logic                  busy_r;
    logic [31:0]           word_cnt_r;
    logic [31:0]           pos_r;
    logic [31:0]           pass_r;
    logic [31:0]           burst_cnt_r;
    logic [31:0]           gap_cnt_r;
    fetch_t                fetch_s;
    logic [31:0]           burst_next_s;

    // Next word as seen from the current read position.
    always_comb begin
        fetch_s      = fetch_next(pos_r, pass_r);
        burst_next_s = burst_cnt_r + 32'd1;
    end

    // Playback FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            data_r      <= '0;
            valid_r     <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            word_cnt_r  <= 32'd0;
            pos_r       <= 32'd0;
            pass_r      <= 32'd0;
            burst_cnt_r <= 32'd0;
            gap_cnt_r   <= 32'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        burst_cnt_r <= 32'd0;
                        if (fetch_s.eof) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_PRESENT;
                            data_r  <= fetch_s.word;
                            valid_r <= 1'b1;
                            busy_r  <= 1'b1;
                            pos_r   <= fetch_s.next_pos;
                            pass_r  <= fetch_s.next_pass;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PRESENT: begin
                    // valid is high throughout this state, so ready alone marks a transfer
                    if (ready) begin
                        word_cnt_r <= word_cnt_r + 32'd1;
                        if (fetch_s.eof) begin
                            state_r <= ST_DONE;
                            valid_r <= 1'b0;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            data_r <= fetch_s.word;
                            pos_r  <= fetch_s.next_pos;
                            pass_r <= fetch_s.next_pass;
                            if ((MODE == 1) && (burst_next_s >= 32'(BURST_LEN))) begin
                                // the fetched word waits out the gap in data_r
                                state_r     <= ST_GAP;
                                valid_r     <= 1'b0;
                                burst_cnt_r <= 32'd0;
                                gap_cnt_r   <= 32'd0;
                            end else begin
                                burst_cnt_r <= burst_next_s;
                            end
                        end
                    end else begin
                        state_r <= ST_PRESENT;
                    end
                end
                ST_GAP: begin
                    if ((gap_cnt_r + 32'd1) >= 32'(GAP_LEN)) begin
                        state_r <= ST_PRESENT;
                        valid_r <= 1'b1;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 32'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign data     = data_r;
    assign valid    = valid_r;
    assign done     = done_r;
    assign busy     = busy_r;
    assign word_cnt = word_cnt_r;

endmodule

// File: tb/tb_data_playback.sv
// -----------------------------------------------------------------------------
// tb_data_playback
//   Directed bench for data_playback. Byte images are supplied through the
//   INIT_BYTES parameter (FILENAME = ""), one instance per scenario:
//     u0 DW16 MODE0 file 01 02 03 04   (table-driven: stream, stall, reset)
//     u1 DW16 MODE0 file 01 02 03      (zero-padded final word, done width)
//     u2 DW8  MODE1 B2 G3 file 11..16  (burst/gap pacing)
//     u3 DW8  empty file               (done without valid)
//     u4 DW8  file 0A 0B NUM_LOOPS=2   (single pass or looped, per macro)
// -----------------------------------------------------------------------------
module tb_data_playback;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // u0
    logic st0 = 1'b0, rd0 = 1'b0;
    logic [15:0] d0; logic v0, dn0, b0; logic [31:0] c0;
    // u1
    logic st1 = 1'b0, rd1 = 1'b0;
    logic [15:0] d1; logic v1, dn1, b1; logic [31:0] c1;
    // u2
    logic st2 = 1'b0, rd2 = 1'b0;
    logic [7:0] d2; logic v2, dn2, b2; logic [31:0] c2;
    // u3
    logic st3 = 1'b0, rd3 = 1'b0;
    logic [7:0] d3; logic v3, dn3, b3; logic [31:0] c3;
    // u4
    logic st4 = 1'b0, rd4 = 1'b0;
    logic [7:0] d4; logic v4, dn4, b4; logic [31:0] c4;

    data_playback #(.FILENAME(""), .DATA_WIDTH(16), .MODE(0), .INIT_LEN(4),
                    .INIT_BYTES(1024'h04030201)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .data(d0), .valid(v0),
        .ready(rd0), .done(dn0), .busy(b0), .word_cnt(c0));

    data_playback #(.FILENAME(""), .DATA_WIDTH(16), .MODE(0), .INIT_LEN(3),
                    .INIT_BYTES(1024'h030201)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .data(d1), .valid(v1),
        .ready(rd1), .done(dn1), .busy(b1), .word_cnt(c1));

    data_playback #(.FILENAME(""), .DATA_WIDTH(8), .MODE(1), .BURST_LEN(2), .GAP_LEN(3),
                    .INIT_LEN(6), .INIT_BYTES(1024'h161514131211)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .data(d2), .valid(v2),
        .ready(rd2), .done(dn2), .busy(b2), .word_cnt(c2));

    data_playback #(.FILENAME(""), .DATA_WIDTH(8), .MODE(0), .INIT_LEN(0)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st3), .data(d3), .valid(v3),
        .ready(rd3), .done(dn3), .busy(b3), .word_cnt(c3));

    data_playback #(.FILENAME(""), .DATA_WIDTH(8), .MODE(0), .NUM_LOOPS(2), .INIT_LEN(2),
                    .INIT_BYTES(1024'h0B0A)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .data(d4), .valid(v4),
        .ready(rd4), .done(dn4), .busy(b4), .word_cnt(c4));

    typedef struct {
        logic        rst;
        logic        start;
        logic        ready;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_done;
        logic        e_busy;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [12:0] vpat;
        logic [7:0]  exp_b;
        logic [7:0]  got_q[$];
        logic [7:0]  exp_q[$];
        logic        seen_done;

        //            rst   start ready  valid data     done  busy  cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0201, 1'b0, 1'b1, 32'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0403, 1'b0, 1'b1, 32'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0403, 1'b1, 1'b0, 32'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0403, 1'b0, 1'b0, 32'd2};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0403, 1'b0, 1'b0, 32'd2};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b1, 32'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b1, 32'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b1, 32'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b1, 32'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b1, 32'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b1, 32'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0403, 1'b0, 1'b1, 32'd1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0403, 1'b0, 1'b1, 32'd1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'd0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0201, 1'b0, 1'b1, 32'd0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0403, 1'b0, 1'b1, 32'd1};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0403, 1'b1, 1'b0, 32'd2};

        // u0 table: {valid, done, busy, data, word_cnt} after each edge
        for (int i = 0; i < NV; i++) begin
            rst_n = ~vecs[i].rst;
            st0   = vecs[i].start;
            rd0   = vecs[i].ready;
            tick();
            check($sformatf("u0_step%0d", i),
                  64'({v0, dn0, b0, d0, c0}),
                  64'({vecs[i].e_valid, vecs[i].e_done, vecs[i].e_busy, vecs[i].e_data, vecs[i].e_cnt}));
        end
        st0 = 1'b0;
        rd0 = 1'b0;

        // u1: short final read is zero-padded; done is exactly one cycle
        do_reset();
        st1 = 1'b1; rd1 = 1'b1;
        tick();
        st1 = 1'b0;
        check("u1_word0", 64'({v1, d1}), 64'({1'b1, 16'h0201}));
        tick();
        check("u1_word1", 64'({v1, d1, c1}), 64'({1'b1, 16'h0003, 32'd1}));
        tick();
        check("u1_done", 64'({v1, dn1, b1, c1}), 64'({1'b0, 1'b1, 1'b0, 32'd2}));
        tick();
        check("u1_done_width", 64'({v1, dn1}), 64'({1'b0, 1'b0}));
        rd1 = 1'b0;

        // u2: burst of 2, gap of 3, 6 words -> 11 000 11 000 11 then done
        do_reset();
        vpat  = 13'b1100011000110;
        exp_b = 8'h11;
        st2 = 1'b1; rd2 = 1'b1;
        for (int k = 0; k < 13; k++) begin
            tick();
            st2 = 1'b0;
            check($sformatf("u2_valid_done%0d", k), 64'({v2, dn2}),
                  64'({vpat[12-k], (k == 12) ? 1'b1 : 1'b0}));
            if (v2) begin
                check($sformatf("u2_data%0d", k), 64'(d2), 64'(exp_b));
                exp_b = exp_b + 8'd1;
            end
        end
        check("u2_word_cnt", 64'(c2), 64'd6);
        rd2 = 1'b0;

        // u3: empty file -> done one cycle after start, no valid
        do_reset();
        st3 = 1'b1; rd3 = 1'b1;
        tick();
        st3 = 1'b0;
        check("u3_empty_done", 64'({v3, dn3, b3}), 64'({1'b0, 1'b1, 1'b0}));
        tick();
        check("u3_after_done", 64'({v3, dn3, c3}), 64'({1'b0, 1'b0, 32'd0}));
        rd3 = 1'b0;

        // u4: collect words until done (bounded)
        do_reset();
`ifdef DATA_PLAYBACK_LOOP_EN
        exp_q = '{8'h0A, 8'h0B, 8'h0A, 8'h0B};
`else
        exp_q = '{8'h0A, 8'h0B};
`endif
        seen_done = 1'b0;
        st4 = 1'b1; rd4 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (!seen_done) begin
                tick();
                st4 = 1'b0;
                if (v4) got_q.push_back(d4);
                if (dn4) seen_done = 1'b1;
            end
        end
        check("u4_done_seen", 64'(seen_done), 64'd1);
        check("u4_word_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_q.size()) begin
                check($sformatf("u4_word%0d", k), 64'(got_q[k]), 64'(exp_q[k]));
            end else begin
                check($sformatf("u4_word%0d_missing", k), 64'hFFFF, 64'(exp_q[k]));
            end
        end
        check("u4_cnt", 64'(c4), 64'(exp_q.size()));
        tick();
        check("u4_single_done", 64'(dn4), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
